// File: rtl/btb_assoc_pkg.sv
// Shared types for the set-associative BTB: branch-type encoding, the stored
// entry layout and the folded-tag helper.
package btb_assoc_pkg;

  localparam int unsigned PC_W      = 30;  // word PC, pc[31:2]
  localparam int unsigned TAG_W_MAX = 15;  // widest folded tag

  typedef enum logic [1:0] {
    PC_RELATIVE = 2'd0,
    CALL        = 2'd1,
    RETURN      = 2'd2,
    INDIRECT    = 2'd3
  } br_type_t;

  typedef struct packed {
    logic [TAG_W_MAX-1:0] tag;
    logic [PC_W-1:0]      bta;
    br_type_t             br_type;
  } btb_entry_t;

  // Fold pc[31:17] onto pc[16:2]; bits above 'width' are forced to zero so a
  // narrow tag still compares correctly in the full-width field.
  function automatic logic [TAG_W_MAX-1:0] mktag(input logic [PC_W-1:0] pc,
                                                  input int unsigned     width);
    logic [TAG_W_MAX-1:0] folded;
    folded = pc[29:15] ^ pc[14:0];
    return folded & TAG_W_MAX'((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/btb_assoc_way.sv
// One way of the BTB: entry RAM (sync read, read-first), valid-bit column in
// flops and a forwarding register that hides the read-first hazard.
// Ports:
//   clk, reset        clock, async active-low reset
//   flush             clear every valid bit
//   rd_en             lookup enable (0 holds read data)
//   rindex            lookup set index this cycle
//   pre_index         registered lookup set index
//   windex, we, wentry  write port (we already qualified by flush/way select)
//   rd_entry_c        entry for the registered lookup
//   rd_vld_c          valid bit for the registered lookup
//   wr_vld_c          valid bit of the set being written
module btb_assoc_way
  import btb_assoc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rindex,
  input  logic [ADDR_WIDTH-1:0] pre_index,
  input  logic [ADDR_WIDTH-1:0] windex,
  input  logic                  we,
  input  btb_entry_t            wentry,
  output btb_entry_t            rd_entry_c,
  output logic                  rd_vld_c,
  output logic                  wr_vld_c
);

  localparam int unsigned SETS = 1 << ADDR_WIDTH;

  btb_entry_t            mem [SETS];
  btb_entry_t            ram_q;
  logic [SETS-1:0]       valid;
  logic                  fwd_on;
  btb_entry_t            fwd_q;
  logic [ADDR_WIDTH-1:0] rd_idx_next;

  // Entry RAM: not reset, guarded by the valid column.
  always_ff @(posedge clk) begin
    if (we) mem[windex] <= wentry;
    if (rd_en) ram_q <= mem[rindex];
  end

  // Valid column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (we) begin
      valid[windex] <= 1'b1;
    end
  end

  // Set that the read data will describe after this edge (held when stalled).
  assign rd_idx_next = rd_en ? rindex : pre_index;

  // A write into the set being read replaces the stale RAM word; this also
  // keeps a stalled result coherent with writes into the held set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_on <= 1'b0;
      fwd_q  <= '0;
    end else if (we && (windex == rd_idx_next)) begin
      fwd_on <= 1'b1;
      fwd_q  <= wentry;
    end else if (rd_en) begin
      fwd_on <= 1'b0;
    end
  end

  assign rd_entry_c = fwd_on ? fwd_q : ram_q;
  assign rd_vld_c   = valid[pre_index];
  assign wr_vld_c   = valid[windex];

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer. Lookup result appears one cycle
// after rd_en; updates come from branch resolution.
// Ports:
//   clk, reset              clock, async active-low reset
//   flush                   invalidate all entries (drops a same-cycle write)
//   rd_en, rpc              lookup enable / lookup PC[31:2]
//   we, wpc, bta_i, br_type_i  update strobe, branch PC, target, type
//   upd_hit, upd_way        lookup metadata returned with the update
//   miss, hit_way           lookup result (hit_way = 0 on miss)
//   bta_o, br_type_o        predicted target/type (fall-through on miss)
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned BANK       = 1,
  parameter int unsigned TAG_WIDTH  = 15,
  parameter int unsigned FALLTHRU   = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       flush,
  input  logic                                       rd_en,
  input  logic [29:0]                                rpc,
  input  logic                                       we,
  input  logic [29:0]                                wpc,
  input  logic [29:0]                                bta_i,
  input  logic [1:0]                                 br_type_i,
  input  logic                                       upd_hit,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] upd_way,
  output logic                                       miss,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] hit_way,
  output logic [29:0]                                bta_o,
  output logic [1:0]                                 br_type_o
);

  localparam int unsigned SETS  = 1 << ADDR_WIDTH;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [ADDR_WIDTH-1:0]            rindex;
  logic [ADDR_WIDTH-1:0]            windex;
  logic [ADDR_WIDTH-1:0]            pre_index;
  logic [TAG_W_MAX-1:0]             rtag;
  logic [TAG_W_MAX-1:0]             pre_tag;
  logic [PC_W-1:0]                  pre_pc;
  btb_entry_t                       wentry;
  btb_entry_t                       rd_entry [WAYS];
  logic [WAYS-1:0]                  rd_vld;
  logic [WAYS-1:0]                  wr_vld;
  logic [WAYS-1:0]                  way_we;
  logic [WAYS-1:0]                  hit;
  logic [WAY_W-1:0]                 sel_way;
  logic                             rr_adv;
  logic [WAY_W-1:0]                 rr_next;
  logic [SETS-1:0][WAY_W-1:0]       rr;

  assign rindex = rpc[BANK +: ADDR_WIDTH];
  assign windex = wpc[BANK +: ADDR_WIDTH];
  assign rtag   = mktag(rpc, TAG_WIDTH);

  assign wentry.tag     = mktag(wpc, TAG_WIDTH);
  assign wentry.bta     = bta_i;
  assign wentry.br_type = br_type_t'(br_type_i);

  // Registered lookup context; held while rd_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_pc    <= '0;
      pre_tag   <= '0;
      pre_index <= '0;
    end else if (rd_en) begin
      pre_pc    <= rpc;
      pre_tag   <= rtag;
      pre_index <= rindex;
    end
  end

  // Victim choice: reported way on an update hit, else lowest invalid way,
  // else the round-robin pointer of the set.
  always_comb begin
    logic found;
    found   = 1'b0;
    sel_way = rr[windex];
    if (upd_hit) begin
      sel_way = upd_way;
    end else begin
      for (int w = 0; w < int'(WAYS); w++) begin
        if (!found && !wr_vld[w]) begin
          sel_way = WAY_W'(w);
          found   = 1'b1;
        end
      end
    end
    rr_adv = we && !flush && !upd_hit && (&wr_vld);
  end

  always_comb begin
    rr_next = '0;
    if (WAYS > 1) rr_next = rr[windex] + WAY_W'(1);
  end

  // Round-robin pointer per set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr <= '0;
    end else if (flush) begin
      rr <= '0;
    end else if (rr_adv) begin
      rr[windex] <= rr_next;
    end
  end

  for (genvar g = 0; g < int'(WAYS); g++) begin : g_way
    assign way_we[g] = we && !flush && (sel_way == WAY_W'(g));

    btb_assoc_way #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_way (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .rd_en      (rd_en),
      .rindex     (rindex),
      .pre_index  (pre_index),
      .windex     (windex),
      .we         (way_we[g]),
      .wentry     (wentry),
      .rd_entry_c (rd_entry[g]),
      .rd_vld_c   (rd_vld[g]),
      .wr_vld_c   (wr_vld[g])
    );

    assign hit[g] = rd_vld[g] && (rd_entry[g].tag == pre_tag);
  end

  // Output mux: lowest hitting way, otherwise fall-through prediction.
  always_comb begin
    miss      = 1'b1;
    hit_way   = '0;
    bta_o     = pre_pc + PC_W'(FALLTHRU);
    br_type_o = PC_RELATIVE;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (miss && hit[w]) begin
        miss      = 1'b0;
        hit_way   = WAY_W'(w);
        bta_o     = rd_entry[w].bta;
        br_type_o = rd_entry[w].br_type;
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with default parameters (128 sets, 2 ways,
// index = rpc[7:1], folded 15-bit tag, fall-through +2 words).
module tb_btb_assoc;
  import btb_assoc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        rd_en;
  logic [29:0] rpc;
  logic        we;
  logic [29:0] wpc;
  logic [29:0] bta_i;
  logic [1:0]  br_type_i;
  logic        upd_hit;
  logic [0:0]  upd_way;
  logic        miss;
  logic [0:0]  hit_way;
  logic [29:0] bta_o;
  logic [1:0]  br_type_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_assoc dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .rd_en     (rd_en),
    .rpc       (rpc),
    .we        (we),
    .wpc       (wpc),
    .bta_i     (bta_i),
    .br_type_i (br_type_i),
    .upd_hit   (upd_hit),
    .upd_way   (upd_way),
    .miss      (miss),
    .hit_way   (hit_way),
    .bta_o     (bta_o),
    .br_type_o (br_type_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic m, input logic [31:0] hw,
                            input logic [31:0] bta, input br_type_t ty);
    chk({tag, ".miss"},    32'(miss),      32'(m));
    chk({tag, ".hit_way"}, 32'(hit_way),   hw);
    chk({tag, ".bta"},     32'(bta_o),     bta);
    chk({tag, ".type"},    32'(br_type_o), 32'(ty));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [29:0] pc, input logic [29:0] bta, input br_type_t ty,
                    input logic uh, input logic uw);
    rd_en     = 1'b0;
    we        = 1'b1;
    wpc       = pc;
    bta_i     = bta;
    br_type_i = ty;
    upd_hit   = uh;
    upd_way   = uw;
    tick();
    we      = 1'b0;
    upd_hit = 1'b0;
  endtask

  task automatic look(input logic [29:0] pc);
    rd_en = 1'b1;
    rpc   = pc;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; rd_en = 1'b0; rpc = '0;
    we = 1'b0; wpc = '0; bta_i = '0; br_type_i = '0; upd_hit = 1'b0; upd_way = '0;

    // Reset values
    #2;
    expect_out("reset", 1'b1, 32'h0, 32'h2, PC_RELATIVE);
    @(negedge clk);
    reset = 1'b1;

    // Cold lookup
    look(30'h100);
    expect_out("cold", 1'b1, 32'h0, 32'h102, PC_RELATIVE);

    // Write then hit
    wr(30'h100, 30'h400, CALL, 1'b0, 1'b0);
    look(30'h100);
    expect_out("hit", 1'b0, 32'h0, 32'h400, CALL);

    // Same-edge write/lookup of a new PC in set 0 -> way 1, forwarded
    we = 1'b1; wpc = 30'h200; bta_i = 30'h600; br_type_i = RETURN; upd_hit = 1'b0;
    rd_en = 1'b1; rpc = 30'h200;
    tick();
    we = 1'b0; rd_en = 1'b0;
    expect_out("fwd_new", 1'b0, 32'h1, 32'h600, RETURN);

    // Same-edge overwrite of an existing way (stale RAM word would give 0x400)
    we = 1'b1; wpc = 30'h100; bta_i = 30'h500; br_type_i = INDIRECT; upd_hit = 1'b1; upd_way = 1'b0;
    rd_en = 1'b1; rpc = 30'h100;
    tick();
    we = 1'b0; upd_hit = 1'b0; rd_en = 1'b0;
    expect_out("fwd_upd", 1'b0, 32'h0, 32'h500, INDIRECT);

    // Stall: outputs hold while rpc changes
    rpc = 30'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("hold%0d", i), 1'b0, 32'h0, 32'h500, INDIRECT);
    end

    // Flush with same-cycle lookup and write
    flush = 1'b1; rd_en = 1'b1; rpc = 30'h100;
    we = 1'b1; wpc = 30'h300; bta_i = 30'h700; br_type_i = CALL; upd_hit = 1'b0;
    tick();
    flush = 1'b0; we = 1'b0; rd_en = 1'b0;
    expect_out("flush_same", 1'b1, 32'h0, 32'h102, PC_RELATIVE);
    look(30'h300);
    expect_out("flush_drop", 1'b1, 32'h0, 32'h302, PC_RELATIVE);
    look(30'h200);
    expect_out("flush_inv", 1'b1, 32'h0, 32'h202, PC_RELATIVE);

    // Set 5: three tags, third evicts way 0 via round robin
    wr(30'h00A, 30'h1000, CALL,     1'b0, 1'b0);
    wr(30'h10A, 30'h2000, RETURN,   1'b0, 1'b0);
    wr(30'h20A, 30'h3000, INDIRECT, 1'b0, 1'b0);
    look(30'h00A);
    expect_out("evict_a", 1'b1, 32'h0, 32'h00C, PC_RELATIVE);
    look(30'h10A);
    expect_out("evict_b", 1'b0, 32'h1, 32'h2000, RETURN);
    look(30'h20A);
    expect_out("evict_c", 1'b0, 32'h0, 32'h3000, INDIRECT);

    // Fourth tag: pointer advanced, evicts way 1
    wr(30'h30A, 30'h4000, CALL, 1'b0, 1'b0);
    look(30'h10A);
    expect_out("rr_b", 1'b1, 32'h0, 32'h10C, PC_RELATIVE);
    look(30'h30A);
    expect_out("rr_d", 1'b0, 32'h1, 32'h4000, CALL);
    look(30'h20A);
    expect_out("rr_c", 1'b0, 32'h0, 32'h3000, INDIRECT);

    // Fall-through wraps modulo 2^30
    look(30'h3FFF_FFFF);
    expect_out("wrap", 1'b1, 32'h0, 32'h1, PC_RELATIVE);

    // Mid-stream reset
    wr(30'h040, 30'h800, CALL, 1'b0, 1'b0);
    look(30'h040);
    expect_out("pre_rst", 1'b0, 32'h0, 32'h800, CALL);
    #2;
    reset = 1'b0;
    #1;
    expect_out("reset_mid", 1'b1, 32'h0, 32'h2, PC_RELATIVE);
    @(negedge clk);
    reset = 1'b1;
    look(30'h040);
    expect_out("post_rst_e", 1'b1, 32'h0, 32'h042, PC_RELATIVE);
    look(30'h100);
    expect_out("post_rst_a", 1'b1, 32'h0, 32'h102, PC_RELATIVE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
